// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the valid/allow_in pipeline chain.
// Imported by pipe_stage and pipe_chain.
package pipe_pkg;

  localparam int STAGES_MAX = 8;
  localparam int DEF_WIDTH  = 64;

  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid bit, payload register and handshake logic.
// Flush kills the stage regardless of its own stall.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_bus,
  input  logic             stall,
  input  logic             flush,
  input  logic             next_allow_in,
  output logic             allow_in,
  output logic             to_next_valid,
  output logic             valid,
  output logic [WIDTH-1:0] bus
);

  logic ready_go;

  assign ready_go      = ~stall;
  assign allow_in      = ~valid | (ready_go & next_allow_in);
  assign to_next_valid = valid & ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      bus   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (allow_in) begin
      valid <= prev_valid;
      if (prev_valid) bus <= prev_bus;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Parameterised valid/allow_in pipeline of STAGES pipe_stage instances
// with per-stage stall and range flush (stages 0..highest flush bit).
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allow_in,
  input  logic [WIDTH-1:0]          in_bus,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic                      out_valid,
  input  logic                      out_allow_in,
  output logic [WIDTH-1:0]          out_bus,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_bus,
  output logic [occ_w(STAGES)-1:0]  occupancy
);

  localparam int OW = occ_w(STAGES);

  logic [STAGES:0]               allow;
  logic [STAGES-1:0]             tnv;
  logic [STAGES-1:0]             pv;
  logic [STAGES-1:0]             kill;
  logic [STAGES-1:0][WIDTH-1:0]  pbus;
  logic [STAGES-1:0][WIDTH-1:0]  bus_q;

  // Suffix-OR: every stage at or below the highest flush bit is killed.
  always_comb begin
    kill = '0;
    kill[STAGES-1] = flush[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      kill[i] = kill[i+1] | flush[i];
    end
  end

  assign allow[STAGES] = out_allow_in;
  assign pv[0]         = in_valid & ~kill[0];
  assign pbus[0]       = in_bus;

  for (genvar i = 1; i < STAGES; i++) begin : g_link
    assign pv[i]   = tnv[i-1] & ~kill[i-1];
    assign pbus[i] = bus_q[i-1];
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk           (clk),
      .reset         (reset),
      .prev_valid    (pv[i]),
      .prev_bus      (pbus[i]),
      .stall         (stall[i]),
      .flush         (kill[i]),
      .next_allow_in (allow[i+1]),
      .allow_in      (allow[i]),
      .to_next_valid (tnv[i]),
      .valid         (stage_valid[i]),
      .bus           (bus_q[i])
    );
  end

  assign in_allow_in = allow[0];
  assign out_valid   = tnv[STAGES-1];
  assign out_bus     = bus_q[STAGES-1];
  assign stage_bus   = bus_q;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OW'(stage_valid[i]);
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (STAGES=5, WIDTH=64).
// An in-order queue tracks items expected at the output.
module tb_pipe_chain;

  localparam int S = 5;
  localparam int W = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_allow_in;
  logic [W-1:0]    in_bus;
  logic [S-1:0]    stall;
  logic [S-1:0]    flush;
  logic            out_valid;
  logic            out_allow_in;
  logic [W-1:0]    out_bus;
  logic [S-1:0]    stage_valid;
  logic [S*W-1:0]  stage_bus;
  logic [2:0]      occupancy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];

  pipe_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_allow_in  (in_allow_in),
    .in_bus       (in_bus),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_allow_in (out_allow_in),
    .out_bus      (out_bus),
    .stage_valid  (stage_valid),
    .stage_bus    (stage_bus),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check/track at negedge, then edge, then advance stimulus.
  task automatic tick();
    logic acc, outx;
    @(negedge clk);
    acc  = in_valid && in_allow_in && (flush == '0) && !reset;
    outx = out_valid && out_allow_in;
    if (outx) begin
      if (q.size() == 0) chk("q_empty", 64'(q.size()), 64'd1);
      else chk("order", out_bus, q.pop_front());
    end
    if (acc) q.push_back(in_bus);
    @(posedge clk);
    #1;
    if (acc) in_bus = in_bus + 1;
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_bus       = '0;
    stall        = '0;
    flush        = '0;
    out_allow_in = 1'b1;
    #3;
    chk("rst_sv", 64'(stage_valid), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ai", 64'(in_allow_in), 64'd1);
    chk("rst_bus", 64'(|stage_bus), 64'd0);

    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_bus   = 64'd1;

    // Latency: first item appears at the output after exactly S edges.
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lat_early", 64'(out_valid), 64'd0);
    end
    tick();
    chk("lat_ov", 64'(out_valid), 64'd1);
    chk("lat_ob", out_bus, 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("occ_full", 64'(occupancy), 64'd5);
    end

    // Stall stage 2 for three cycles with a full pipe.
    stall = 5'b00100;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ai", 64'(in_allow_in), 64'd0);
      tick();
      chk("stall_bub", 64'(stage_valid[3]), 64'd0);
    end
    chk("stall_sv", 64'(stage_valid), 64'h07);
    chk("stall_s2", stage_bus[2*W +: W], in_bus - 3);
    stall = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("refill", 64'(occupancy), 64'd5);

    // Downstream backpressure for ten cycles.
    out_allow_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_ob", out_bus, q[0]);
    end
    chk("bp_occ", 64'(occupancy), 64'd5);
    chk("bp_ai", 64'(in_allow_in), 64'd0);

    // Flush stages 0..1 while the pipe is frozen.
    flush = 5'b00010;
    tick();
    flush = '0;
    chk("fl1_sv", 64'(stage_valid), 64'h1c);
    chk("fl1_s2", stage_bus[2*W +: W], q[2]);
    chk("fl1_occ", 64'(occupancy), 64'd3);
    void'(q.pop_back());
    void'(q.pop_back());
    out_allow_in = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("fl1_refill", 64'(occupancy), 64'd5);

    // Flush and stall on the same stage: flush wins.
    stall = 5'b00010;
    flush = 5'b00010;
    tick();
    stall = '0;
    flush = '0;
    chk("flst_sv", 64'(stage_valid), 64'h18);
    void'(q.pop_back());
    void'(q.pop_back());
    for (int c = 0; c < 6; c++) tick();

    // Flush stage 0 while flowing: input ignored, allow_in unaffected.
    flush = 5'b00001;
    #1;
    chk("fl0_ai", 64'(in_allow_in), 64'd1);
    tick();
    flush = '0;
    chk("fl0_sv", 64'(stage_valid), 64'h1c);
    void'(q.pop_back());
    for (int c = 0; c < 6; c++) tick();

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sv", 64'(stage_valid), 64'd0);
    chk("arst_ov", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    q.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_lat", 64'(out_valid), 64'd0);
    end
    tick();
    chk("arst_ov2", 64'(out_valid), 64'd1);
    chk("arst_ob", out_bus, q[0]);
    for (int c = 0; c < 4; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages (legal range 2..8).
REQ-002 SHALL have parameter WIDTH, default 64, payload bus width in bits per stage.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_allow_in  output  1  stage 0 can accept this cycle.
REQ-007 SHALL have port in_bus  input  WIDTH  upstream payload.
REQ-008 SHALL have port stall  input  STAGES  per-stage hold request; bit i high means stage i is not ready_go.
REQ-009 SHALL have port flush  input  STAGES  per-stage kill request.
REQ-010 SHALL have port out_valid  output  1  last-stage payload valid and ready_go.
REQ-011 SHALL have port out_allow_in  input  1  downstream can accept.
REQ-012 SHALL have port out_bus  output  WIDTH  last-stage payload.
REQ-013 SHALL have port stage_valid  output  STAGES  valid bit of every stage, for hazard/forwarding logic.
REQ-014 SHALL have port stage_bus  output  STAGES*WIDTH  payload of every stage; stage i occupies bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port occupancy  output  $clog2(STAGES+1)  count of valid stages.

Function
REQ-016 Stage i SHALL compute ready_go_i = ~stall[i] and allow_in_i = ~valid_i | (ready_go_i & allow_in_{i+1}), with allow_in_STAGES = out_allow_in.
REQ-017 Stage i SHALL present to_next_valid_i = valid_i & ready_go_i; to_next_valid_{-1} = in_valid.
REQ-018 When allow_in_i is high, stage i SHALL load valid_i <= to_next_valid_{i-1}, and SHALL load its payload only if to_next_valid_{i-1} is also high.
REQ-019 When allow_in_i is low, stage i SHALL hold valid and payload unchanged.
REQ-020 in_allow_in SHALL equal allow_in_0; out_valid SHALL equal to_next_valid_{STAGES-1}; out_bus SHALL equal the last-stage payload.
REQ-021 With no stall and no flush and out_allow_in high, latency in->out SHALL be exactly STAGES cycles at throughput one transfer per cycle.
REQ-022 Let k be the highest set bit of flush; at the next edge, valid of stages 0..k SHALL be cleared, and stages above k SHALL NOT capture from stage k.
REQ-023 During a flush cycle in_valid SHALL be ignored (no capture into stage 0); in_allow_in remains as computed by REQ-016.
REQ-024 Stages above k SHALL advance normally during a flush cycle, including transfer to the downstream.
REQ-025 Flush SHALL override stall for the flushed stages.
REQ-026 A stalled stage whose successor is empty SHALL emit a bubble (successor valid cleared) rather than duplicate its payload.
REQ-027 Payload registers of invalid stages SHALL NOT be required to hold any particular value; stage_bus of an invalid stage is don't-care.
REQ-028 occupancy SHALL equal the population count of stage_valid, combinationally from registered state.

Reset
REQ-029 On reset assertion, all valid bits SHALL clear asynchronously; all payload registers SHALL clear to 0.
REQ-030 During reset, out_valid = 0, occupancy = 0, stage_valid = 0, in_allow_in = 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight payloads; no transfer completes on the edge reset is deasserted.

Structure
REQ-032 Shared package pipe_pkg SHALL hold STAGES_MAX (8), the default WIDTH, and the occupancy-width function.
REQ-033 Sub-module pipe_stage (one stage: valid bit, payload register, ready_go/allow_in logic, flush input) SHALL be instantiated STAGES times via generate.
REQ-034 Flush-range decode (highest set bit to thermometer mask) SHALL live in pipe_chain, not in pipe_stage.

Verification
REQ-035 STAGES=5, no stall, out_allow_in=1, in_bus=1,2,3,... each cycle -> out_bus=1 appears 5 cycles after first accept, then consecutive values, occupancy=5 steady.
REQ-036 Stall[2] held 3 cycles with a full pipe -> stages 0..2 hold, stage 3 gets 3 bubbles, in_allow_in=0 for those 3 cycles, no payload lost or duplicated.
REQ-037 out_allow_in=0 for 10 cycles with in_valid=1 -> pipe fills to occupancy=5, in_allow_in=0, out_bus stable; release -> order preserved.
REQ-038 flush=5'b00010 with stages all valid -> next cycle stage_valid=5'b11100, in_bus of that cycle not captured, stage 2 keeps prior stage-2 payload and does not receive stage 1's.
REQ-039 flush[1] and stall[1] together -> flush wins: stages 0..1 invalid next cycle.
REQ-040 reset pulse asserted asynchronously mid-stream (between edges) -> stage_valid=0 and out_valid=0 immediately; after deassert first output is STAGES cycles after next accepted input.
